div_recompose: RTL and testbench

- Pipelined inverse of the N-bit unsigned divider: rebuilds dividend = quotient*divisor + remainder.
- Shift-add, one quotient bit per stage; accepts one operand set per clock; no backpressure.
- Sits on the divider's output side as the result-reconstruction/self-check path, in both the bench and on-chip BIST.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_recompose_stage.sv | 60 ++++++
 rtl/div_recompose.sv | 123 ++++++++++++
 tb/tb_div_recompose.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants for the divider and its recompose/self-check path.
// Flag bit positions are common to divider-side status and recompose flags.
package div_pkg;

  localparam int DIV_N     = 8;
  localparam int DIV_ACC_W = 2 * DIV_N;

  // Status flag bit positions.
  localparam int DIV0     = 0;
  localparam int REM_ERR  = 1;
  localparam int OVERFLOW = 2;

  // Only DIV0 and REM_ERR travel down the pipeline; OVERFLOW is derived at the output.
  localparam int PIPE_FLAG_W = 2;

endpackage

// File: rtl/div_recompose_stage.sv
// One shift-add stage: adds divisor << (K-1) when the current low quotient bit is set,
// then registers the accumulator, operands, side-band bits and valid.
module div_recompose_stage
  import div_pkg::*;
#(
  parameter int N  = DIV_N,
  parameter int K  = 1,
  parameter int SW = PIPE_FLAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [2*N-1:0]   acc_i,
  input  logic [N-1:0]     divisor_i,
  input  logic [N-1:0]     quot_i,
  input  logic [SW-1:0]    side_i,
  output logic             valid_o,
  output logic [2*N-1:0]   acc_o,
  output logic [N-1:0]     divisor_o,
  output logic [N-1:0]     quot_o,
  output logic [SW-1:0]    side_o
);

  logic             valid_q;
  logic [2*N-1:0]   acc_q, acc_d, addend_d;
  logic [N-1:0]     divisor_q, quot_q;
  logic [SW-1:0]    side_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    addend_d = '0;
    if (quot_i[0]) addend_d = {{N{1'b0}}, divisor_i} << (K - 1);
    acc_d = acc_i + addend_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: data registers are cleared as well, so a reset pipeline holds all-zero state.
      valid_q   <= 1'b0;
      acc_q     <= '0;
      divisor_q <= '0;
      quot_q    <= '0;
      side_q    <= '0;
    end else begin
      // NOTE: non-blocking so each stage samples its predecessor's pre-edge value.
      valid_q   <= valid_i;
      acc_q     <= acc_d;
      divisor_q <= divisor_i;
      quot_q    <= quot_i >> 1;
      side_q    <= side_i;
    end
  end

  assign valid_o   = valid_q;
  assign acc_o     = acc_q;
  assign divisor_o = divisor_q;
  assign quot_o    = quot_q;
  assign side_o    = side_q;

endmodule

// File: rtl/div_recompose.sv
// Pipelined inverse of the N-bit divider: dividend = quotient*divisor + remainder, N-cycle latency.
// Optional expected-value checker enabled by DIV_RECOMPOSE_CHECK_EN (mismatch, err_cnt).
module div_recompose
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [N-1:0]     quotient,
  input  logic [N-1:0]     divisor,
  input  logic [N-1:0]     remainder,
`ifdef DIV_RECOMPOSE_CHECK_EN
  input  logic [N-1:0]     exp_dividend,
`endif
  output logic             valid_out,
  output logic [2*N-1:0]   dividend,
  output logic             overflow,
  output logic             div0,
  output logic             rem_err
`ifdef DIV_RECOMPOSE_CHECK_EN
  ,
  output logic             mismatch,
  output logic [15:0]      err_cnt
`endif
);

  localparam int ACC_W = 2 * N;
`ifdef DIV_RECOMPOSE_CHECK_EN
  localparam int SW = PIPE_FLAG_W + N;
`else
  localparam int SW = PIPE_FLAG_W;
`endif

  logic             valid_c   [0:N];
  logic [ACC_W-1:0] acc_c     [0:N];
  logic [N-1:0]     divisor_c [0:N];
  logic [N-1:0]     quot_c    [0:N];
  logic [SW-1:0]    side_c    [0:N];

  logic [PIPE_FLAG_W-1:0] flags0;

  // Stage 0 capture is combinational so the N registered stages give exactly N cycles latency.
  always_comb begin
    flags0          = '0;
    flags0[DIV0]    = (divisor == '0);
    flags0[REM_ERR] = (remainder >= divisor);
  end

  assign valid_c[0]   = valid_in;
  assign acc_c[0]     = {{N{1'b0}}, remainder};
  assign divisor_c[0] = divisor;
  assign quot_c[0]    = quotient;
`ifdef DIV_RECOMPOSE_CHECK_EN
  assign side_c[0]    = {exp_dividend, flags0};
`else
  assign side_c[0]    = flags0;
`endif

  for (genvar k = 1; k <= N; k++) begin : g_stage
    div_recompose_stage #(
      .N  (N),
      .K  (k),
      .SW (SW)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .valid_i   (valid_c[k-1]),
      .acc_i     (acc_c[k-1]),
      .divisor_i (divisor_c[k-1]),
      .quot_i    (quot_c[k-1]),
      .side_i    (side_c[k-1]),
      .valid_o   (valid_c[k]),
      .acc_o     (acc_c[k]),
      .divisor_o (divisor_c[k]),
      .quot_o    (quot_c[k]),
      .side_o    (side_c[k])
    );
  end

  assign valid_out = valid_c[N];

  // Outputs are forced to zero in bubble slots.
  always_comb begin
    dividend = '0;
    overflow = 1'b0;
    div0     = 1'b0;
    rem_err  = 1'b0;
    if (valid_c[N]) begin
      dividend = acc_c[N];
      overflow = |acc_c[N][ACC_W-1:N];
      div0     = side_c[N][DIV0];
      rem_err  = side_c[N][REM_ERR];
    end
  end

  // By the last stage every quotient bit has been consumed and the carried divisor agrees with div0.
  always_comb begin
    if (valid_c[N]) begin
      assert (quot_c[N] == '0);
      assert ((divisor_c[N] == '0) == side_c[N][DIV0]);
    end
  end

`ifdef DIV_RECOMPOSE_CHECK_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    mismatch  = valid_c[N] && (acc_c[N] != {{N{1'b0}}, side_c[N][SW-1:PIPE_FLAG_W]});
    err_cnt_d = err_cnt_q;
    if (mismatch && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_div_recompose.sv
// Self-checking bench for div_recompose: arithmetic reference model keyed by output cycle,
// directed literal cases, random streams, mid-stream reset, and (optional) checker port tests.
module tb_div_recompose;
  import div_pkg::*;

  localparam int N = DIV_N;

  logic           clk = 1'b0;
  logic           rst;
  logic           valid_in;
  logic [N-1:0]   quotient, divisor, remainder, exp_dividend;
  logic           valid_out;
  logic [2*N-1:0] dividend;
  logic           overflow, div0, rem_err;
`ifdef DIV_RECOMPOSE_CHECK_EN
  logic           mismatch;
  logic [15:0]    err_cnt;
`endif

  div_recompose #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .quotient     (quotient),
    .divisor      (divisor),
    .remainder    (remainder),
`ifdef DIV_RECOMPOSE_CHECK_EN
    .exp_dividend (exp_dividend),
`endif
    .valid_out    (valid_out),
    .dividend     (dividend),
    .overflow     (overflow),
    .div0         (div0),
    .rem_err      (rem_err)
`ifdef DIV_RECOMPOSE_CHECK_EN
    ,
    .mismatch     (mismatch),
    .err_cnt      (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    int unsigned a;
    bit          ov;
    bit          d0;
    bit          re;
    bit          mm;
  } exp_t;

  exp_t        sched [int];     // expected output, keyed by the edge after which it is visible
  int          errors = 0;
  int          checks = 0;
  int          edge_cnt = 0;
  bit          last_rst = 1'b0;
  int unsigned model_cnt = 0;
  bit          mm_seen;
  int unsigned cnt_after;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: an accepted operand set is visible N-1 edges after the edge that samples it.
  always @(posedge clk) begin
    int   c;
    exp_t e;
    c = edge_cnt;
    if (rst) begin
      for (int k = c; k < c + N; k++)
        if (sched.exists(k)) sched.delete(k);
    end else if (valid_in) begin
      e.v  = 1'b1;
      e.a  = int'(quotient) * int'(divisor) + int'(remainder);
      e.ov = (e.a >= (1 << N));
      e.d0 = (divisor == 0);
      e.re = (remainder >= divisor);
      e.mm = (e.a != int'(exp_dividend));
      sched[c + N - 1] = e;
    end
    last_rst = rst;
    edge_cnt++;
  end

  // Compare every cycle against the model, half a cycle after the edge.
  always @(negedge clk) begin
    exp_t e;
    int   key;
    if (edge_cnt > 0) begin
      key = edge_cnt - 1;
      e = '{default: 0};
      if (sched.exists(key)) begin
        e = sched[key];
        sched.delete(key);
      end
      check("valid_out", valid_out, e.v);
      check("dividend", dividend, e.v ? e.a : 0);
      check("overflow", overflow, e.v & e.ov);
      check("div0", div0, e.v & e.d0);
      check("rem_err", rem_err, e.v & e.re);
`ifdef DIV_RECOMPOSE_CHECK_EN
      if (last_rst) model_cnt = 0;
      check("err_cnt", err_cnt, model_cnt);
      check("mismatch", mismatch, e.v & e.mm);
      if (e.v && e.mm && model_cnt < 65535) model_cnt++;
`endif
    end
  end

  // Single operand pulse followed by junk bubble data; checks latency and literal results.
  task automatic directed(input logic [N-1:0] q, input logic [N-1:0] d, input logic [N-1:0] r,
                          input logic [N-1:0] ex, input int unsigned want,
                          input bit w_ov, input bit w_d0, input bit w_re);
    int lat;
    quotient = q; divisor = d; remainder = r; exp_dividend = ex; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    quotient = N'($urandom); divisor = N'($urandom); remainder = N'($urandom);
    lat = 1;
    while (!valid_out && lat < 2 * N) begin
      @(negedge clk);
      lat++;
    end
    check("lit_latency", lat, N);
    check("lit_dividend", dividend, want);
    check("lit_overflow", overflow, w_ov);
    check("lit_div0", div0, w_d0);
    check("lit_rem_err", rem_err, w_re);
`ifdef DIV_RECOMPOSE_CHECK_EN
    mm_seen = mismatch;
`endif
    @(negedge clk);
    check("lit_single_pulse", valid_out, 0);
`ifdef DIV_RECOMPOSE_CHECK_EN
    cnt_after = err_cnt;
`endif
  endtask

  // Back-to-back random consistent divider results; optional one-cycle reset at input index rst_at.
  task automatic stream(input int n, input int rst_at, input int want_first, input int want_cnt);
    int first, cnt, a, d;
    first = -1;
    cnt = 0;
    for (int i = 0; i < n + 2 * N; i++) begin
      if (i < n) begin
        a = int'($urandom_range(0, (1 << N) - 1));
        d = int'($urandom_range(1, (1 << N) - 1));
        quotient = N'(a / d); divisor = N'(d); remainder = N'(a % d); exp_dividend = N'(a);
        valid_in = 1'b1;
        rst = (i == rst_at);
      end else begin
        valid_in = 1'b0;
        rst = 1'b0;
      end
      @(negedge clk);
      if (valid_out && first < 0) first = i + 1;
      if (valid_out) cnt++;
    end
    check("stream_first_valid", first, want_first);
    check("stream_valid_count", cnt, want_cnt);
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0;
    quotient = '0; divisor = '0; remainder = '0; exp_dividend = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    directed(8'd5,   8'd7,   8'd3,   8'd38,  38,    1'b0, 1'b0, 1'b0);
    directed(8'd255, 8'd255, 8'd254, 8'hFF,  65279, 1'b1, 1'b0, 1'b0);
    directed(8'd17,  8'd0,   8'd9,   8'd9,   9,     1'b0, 1'b1, 1'b1);

    stream(100, -1, N, 100);
    stream(40, 3, N + 4, 36);

`ifdef DIV_RECOMPOSE_CHECK_EN
    check("err_cnt_after_reset", err_cnt, 0);
    directed(8'd5, 8'd7, 8'd3, 8'd39, 38, 1'b0, 1'b0, 1'b0);
    check("lit_mismatch_bad_exp", mm_seen, 1);
    check("lit_err_cnt_bad_exp", cnt_after, 1);
    directed(8'd5, 8'd7, 8'd3, 8'd38, 38, 1'b0, 1'b0, 1'b0);
    check("lit_mismatch_good_exp", mm_seen, 0);
    check("lit_err_cnt_good_exp", cnt_after, 1);
`endif

    repeat (2 * N) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
